// File: rtl/draw_rect_char.sv
// Text-overlay stage of the VGA pipeline: addresses the character/font lookup
// from the pixel position and composites returned glyph pixels over the stream.
module draw_rect_char #(
  parameter int          XPOS     = 100,
  parameter int          YPOS     = 50,
  parameter int          COLS     = 13,
  parameter int          ROWS     = 1,
  parameter logic [11:0] TEXT_RGB = 12'hFFF
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [7:0]  char_xy,
  output logic [3:0]  char_line,
  input  logic [7:0]  char_line_pixels,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  localparam logic [10:0] X0 = 11'(XPOS);
  localparam logic [10:0] X1 = 11'(XPOS + 8 * COLS);
  localparam logic [10:0] Y0 = 11'(YPOS);
  localparam logic [10:0] Y1 = 11'(YPOS + 16 * ROWS);
  localparam logic [6:0]  X0_LO = X0[6:0];
  localparam logic [7:0]  Y0_LO = Y0[7:0];

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_t;

  vga_t       vga_in, s1, s2, s3;
  logic [6:0] x_rel;
  logic [7:0] y_rel;
  logic       in_box_c;
  logic       s1_in_box, s2_in_box;
  logic [2:0] s1_bit, s2_bit;
  logic       glyph_on;

  // Only the low bits of the offsets are used, so narrower subtractions suffice.
  always_comb begin
    vga_in   = '{hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in};
    x_rel    = hcount_in[6:0] - X0_LO;
    y_rel    = vcount_in[7:0] - Y0_LO;
    in_box_c = (hcount_in >= X0) && (hcount_in < X1) &&
               (vcount_in >= Y0) && (vcount_in < Y1);
    glyph_on = s2_in_box && char_line_pixels[3'd7 - s2_bit];
  end

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the previous stage's pre-edge value.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      s1        <= '0;
      s2        <= '0;
      s3        <= '0;
      s1_in_box <= 1'b0;
      s2_in_box <= 1'b0;
      s1_bit    <= '0;
      s2_bit    <= '0;
      char_xy   <= '0;
      char_line <= '0;
      rgb_out   <= '0;
    end else begin
      s1        <= vga_in;
      s1_in_box <= in_box_c;
      s1_bit    <= in_box_c ? x_rel[2:0] : 3'd0;
      char_xy   <= in_box_c ? {y_rel[7:4], x_rel[6:3]} : 8'h00;
      char_line <= in_box_c ? y_rel[3:0] : 4'h0;

      s2        <= s1;
      s2_in_box <= s1_in_box;
      s2_bit    <= s1_bit;

      s3        <= s2;
      if (s2.hblnk || s2.vblnk) rgb_out <= 12'h000;
      else if (glyph_on)        rgb_out <= TEXT_RGB;
      else                      rgb_out <= s2.rgb;
    end
  end

  assign hcount_out = s3.hcount;
  assign vcount_out = s3.vcount;
  assign hsync_out  = s3.hsync;
  assign vsync_out  = s3.vsync;
  assign hblnk_out  = s3.hblnk;
  assign vblnk_out  = s3.vblnk;

endmodule

// File: tb/tb_draw_rect_char.sv
// Self-checking bench for draw_rect_char: a synchronous font-ROM stub and a
// position-arithmetic reference model with a 3-deep output history.
module tb_draw_rect_char;
  localparam int          XPOS = 100;
  localparam int          YPOS = 50;
  localparam int          COLS = 13;
  localparam int          ROWS = 1;
  localparam logic [11:0] TEXT = 12'hFFF;

  logic        pclk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in;
  logic [7:0]  char_xy;
  logic [3:0]  char_line;
  logic [7:0]  char_line_pixels = 8'h00;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  int checks = 0;
  int errors = 0;

  int         font_mode = 0;
  logic [7:0] fixed_pat = 8'h81;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic [3:0]  tim;
    logic [11:0] rgb;
    logic [7:0]  cxy;
    logic [3:0]  line;
  } entry_t;

  entry_t hist[$];

  draw_rect_char #(.XPOS(XPOS), .YPOS(YPOS), .COLS(COLS), .ROWS(ROWS), .TEXT_RGB(TEXT)) dut (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in),
    .char_xy(char_xy), .char_line(char_line), .char_line_pixels(char_line_pixels),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  always #5 pclk = ~pclk;

  function automatic logic [7:0] font_fn(logic [7:0] cxy, logic [3:0] line);
    int v;
    if (font_mode == 0) return fixed_pat;
    v = {20'd0, cxy, line};
    return 8'((v * 37) ^ (v >> 5) ^ 8'h5A);
  endfunction

  // Synchronous font ROM with one cycle of latency, addressed by the glyph slot.
  always @(posedge pclk) char_line_pixels <= font_fn(char_xy, char_line);

  function automatic entry_t model(logic [10:0] h, logic [10:0] v, logic [3:0] tim,
                                   logic [11:0] rgb);
    entry_t     e;
    int         hi = int'(h);
    int         vi = int'(v);
    logic [7:0] pix;
    e.h = h; e.v = v; e.tim = tim; e.rgb = rgb; e.cxy = 8'h00; e.line = 4'h0;
    if (hi >= XPOS && hi < XPOS + 8 * COLS && vi >= YPOS && vi < YPOS + 16 * ROWS) begin
      e.cxy  = 8'(((vi - YPOS) / 16) * 16 + (hi - XPOS) / 8);
      e.line = 4'((vi - YPOS) % 16);
      pix    = font_fn(e.cxy, e.line);
      if (pix[7 - ((hi - XPOS) % 8)]) e.rgb = TEXT;
    end
    if (tim[1] || tim[0]) e.rgb = 12'h000;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [10:0] h, input logic [10:0] v, input logic hs,
                      input logic vs, input logic hb, input logic vb, input logic [11:0] rgb);
    entry_t e;
    hcount_in = h; vcount_in = v;
    hsync_in = hs; vsync_in = vs; hblnk_in = hb; vblnk_in = vb; rgb_in = rgb;
    hist.push_back(model(h, v, {hs, vs, hb, vb}, rgb));
    @(posedge pclk); #1;
    e = hist[hist.size() - 3];
    check("hcount_out", 32'(hcount_out), 32'(e.h));
    check("vcount_out", 32'(vcount_out), 32'(e.v));
    check("timing_out", 32'({hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'(e.tim));
    check("rgb_out", 32'(rgb_out), 32'(e.rgb));
    check("char_xy", 32'(char_xy), 32'(hist[$].cxy));
    check("char_line", 32'(char_line), 32'(hist[$].line));
    if (hist.size() > 8) void'(hist.pop_front());
  endtask

  // Called just after a rising edge; reset is pulsed entirely between edges.
  task automatic do_reset();
    hcount_in = 11'($urandom); vcount_in = 11'($urandom);
    {hsync_in, vsync_in, hblnk_in, vblnk_in} = 4'($urandom);
    rgb_in = 12'($urandom);
    #2 rst = 1'b0;
    #1;
    check("rst_char_xy", 32'(char_xy), 32'h0);
    check("rst_char_line", 32'(char_line), 32'h0);
    check("rst_rgb_out", 32'(rgb_out), 32'h0);
    check("rst_pos_out", 32'({hcount_out, vcount_out}), 32'h0);
    check("rst_timing_out", 32'({hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'h0);
    #1 rst = 1'b1;
    hist.delete();
    hist.push_back('0);
    hist.push_back('0);
  endtask

  // An out-of-box idle step lets the ROM finish the last real read before the font changes.
  task automatic set_font(input int mode, input logic [7:0] pat);
    step(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    font_mode = mode;
    fixed_pat = pat;
  endtask

  logic [11:0] sweep[8];

  initial begin
    rst = 1'b0;
    hcount_in = '0; vcount_in = '0; rgb_in = '0;
    {hsync_in, vsync_in, hblnk_in, vblnk_in} = '0;
    @(posedge pclk); #1;
    do_reset();

    // Hold inputs after release: model yields zeros for two edges, then live data.
    repeat (4) step(11'd150, 11'd60, 1'b1, 1'b0, 1'b0, 1'b0, 12'h3C7);

    // Addressing at box corners and just beyond.
    set_font(1, 8'h00);
    step(11'd100, 11'd50, 1'b0, 1'b0, 1'b0, 1'b0, 12'h111);
    check("addr_100_50", 32'({char_xy, char_line}), 32'h000);
    step(11'd203, 11'd65, 1'b0, 1'b0, 1'b0, 1'b0, 12'h222);
    check("addr_203_65", 32'({char_xy, char_line}), 32'h0CF);
    step(11'd204, 11'd65, 1'b0, 1'b0, 1'b0, 1'b0, 12'h333);
    check("addr_204_65", 32'({char_xy, char_line}), 32'h000);
    step(11'd150, 11'd66, 1'b0, 1'b0, 1'b0, 1'b0, 12'h444);
    check("addr_150_66", 32'({char_xy, char_line}), 32'h000);

    // Latency: a single-cycle hsync pulse carrying a distinct colour.
    step(11'd20, 11'd5, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0A5);
    step(11'd21, 11'd5, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    step(11'd22, 11'd5, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    check("lat_hsync", 32'({hsync_out, rgb_out}), 32'h10A5);
    check("lat_pos", 32'({hcount_out, vcount_out}), 32'({11'd20, 11'd5}));

    // Glyph overlay and blanking over one character cell.
    for (int b = 0; b < 2; b++) begin
      set_font(0, 8'b1000_0001);
      for (int j = 0; j < 10; j++) begin
        if (j < 8) step(11'(100 + j), 11'd50, 1'b0, 1'b0, 1'(b), 1'b0, 12'h123);
        else       step(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        if (j >= 2) sweep[j - 2] = rgb_out;
      end
      for (int k = 0; k < 8; k++)
        check(b ? "blank_sweep" : "glyph_sweep", 32'(sweep[k]),
              b ? 32'h000 : ((k == 0 || k == 7) ? 32'hFFF : 32'h123));
    end

    // Just outside the box with a solid font: background must pass through.
    set_font(0, 8'hFF);
    step(11'd99, 11'd50, 1'b0, 1'b0, 1'b0, 1'b0, 12'h5A5);
    step(11'd150, 11'd49, 1'b0, 1'b0, 1'b0, 1'b0, 12'h6B6);
    step(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    check("outside_99", 32'(rgb_out), 32'h5A5);
    step(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    check("outside_49", 32'(rgb_out), 32'h6B6);

    // Mid-frame reset with glyphs in flight, then hold inputs in the box.
    for (int j = 0; j < 4; j++) step(11'(100 + j), 11'd52, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0F0);
    do_reset();
    repeat (4) step(11'd108, 11'd53, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0F0);

    // Randomized traffic around the box with a content-dependent font.
    set_font(1, 8'h00);
    for (int n = 0; n < 400; n++) begin
      logic [10:0] h, v;
      logic [3:0]  t;
      h = ($urandom_range(0, 9) == 0) ? 11'($urandom) : 11'($urandom_range(90, 215));
      v = ($urandom_range(0, 9) == 0) ? 11'($urandom) : 11'($urandom_range(44, 70));
      t = 4'($urandom);
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      step(h, v, t[3], t[2], t[1], t[0], 12'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
